load_store_unit: RTL

// Memory-side producer of FinalDataMemoryRead, which the writeback result mux consumes as RESULT_MEM.
// - Accepts one load or store per request from the MEM stage.
// - Drives a req/ack handshake to data memory and aligns byte lanes for stores.
// - Extracts and sign/zero-extends load data, and stalls the pipeline until the access completes.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module      : load_store_unit_if
// Description : Data-memory req/ack bus between the load/store unit and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemByteEn;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        output MemAck, MemRData
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store engine; produces FinalDataMemoryRead.
//               Define MISALIGN_TRAP_EN to trap misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        MemRead,
    input  wire logic        MemWrite,
    input  wire logic [2:0]  Funct3,
    input  wire logic [31:0] Address,
    input  wire logic [31:0] WriteData,
    output logic             Stall,
    output logic [31:0]      FinalDataMemoryRead,
    output logic             LoadValid,
    output logic             BusError,
    output logic             MisalignFault,
    load_store_unit_if.master mem
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam int         c_CW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    logic [1:0]      r_state;
    logic            r_is_load;
    logic            r_timeout;
    logic            r_misalign;
    logic [2:0]      r_funct3;
    logic [1:0]      r_ofs;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_rdata;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;

    logic            w_req;
    logic            w_is_byte;
    logic            w_is_half;
    logic            w_misalign;
    logic            w_timeout;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;

    // Funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word
    assign w_req     = MemRead | MemWrite;
    assign w_is_byte = (Funct3[1:0] == 2'b00);
    assign w_is_half = (Funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half & Address[0]) |
                        (~w_is_byte & ~w_is_half & (Address[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_timeout = (ACK_TIMEOUT != 0) &&
                       ({{(32-c_CW){1'b0}}, r_cnt} == 32'(ACK_TIMEOUT - 1));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
        if (w_is_byte) begin
            w_be    = 4'b0001 << Address[1:0];
            w_wdata = {4{WriteData[7:0]}};
        end else if (w_is_half) begin
            w_be    = Address[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{WriteData[15:0]}};
        end
    end

    function automatic logic [31:0] f_extract(input logic [2:0]  f3,
                                              input logic [1:0]  ofs,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = ofs[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  f_extract = {{24{b[7]}}, b};
            3'b100:  f_extract = {24'd0, b};
            3'b001:  f_extract = {{16{h[15]}}, h};
            3'b101:  f_extract = {16'd0, h};
            default: f_extract = w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_is_load  <= 1'b0;
            r_timeout  <= 1'b0;
            r_misalign <= 1'b0;
            r_funct3   <= 3'd0;
            r_ofs      <= 2'd0;
            r_cnt      <= '0;
            r_rdata    <= 32'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_is_load  <= MemRead & ~MemWrite;
                        r_we       <= MemWrite;
                        r_addr     <= {Address[31:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_funct3   <= Funct3;
                        r_ofs      <= Address[1:0];
                        r_cnt      <= '0;
                        r_timeout  <= 1'b0;
                        r_misalign <= w_misalign;
                        r_state    <= w_misalign ? c_DONE : c_REQ;
                    end
                end
                c_REQ: begin
                    if (mem.MemAck) begin
                        if (r_is_load) begin
                            r_rdata <= f_extract(r_funct3, r_ofs, mem.MemRData);
                        end
                        r_state <= c_DONE;
                    end else if (w_timeout) begin
                        r_timeout <= 1'b1;
                        if (r_is_load) begin
                            r_rdata <= 32'd0;
                        end
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Reset is folded in so an abandoned access releases the pipeline at once
    assign Stall = ~reset & (((r_state == c_IDLE) & w_req) | (r_state == c_REQ));

    assign FinalDataMemoryRead = r_rdata;
    assign LoadValid           = (r_state == c_DONE) & r_is_load & ~r_misalign;
    assign BusError            = (r_state == c_DONE) & r_timeout;
    assign MisalignFault       = (r_state == c_DONE) & r_misalign;

    assign mem.MemReq    = (r_state == c_REQ);
    assign mem.MemWe     = r_we;
    assign mem.MemAddr   = r_addr;
    assign mem.MemWData  = r_wdata;
    assign mem.MemByteEn = r_be;

endmodule

`default_nettype wire
